// File: rtl/axi_lite_master_if.sv
// AXI4-lite bus bundle between one initiator and one target.
// The master modport is the initiator side; slave is the target side.
interface axi_lite_master_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
   logic                      AWVALID;
   logic                      AWREADY;
   logic [AXI_ADDR_WIDTH-1:0] AWADDR;
   logic [2:0]                AWPROT;
   logic                      WVALID;
   logic                      WREADY;
   logic [AXI_DATA_WIDTH-1:0] WDATA;
   logic [AXI_STRB_WIDTH-1:0] WSTRB;
   logic                      BVALID;
   logic                      BREADY;
   logic [1:0]                BRESP;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [AXI_ADDR_WIDTH-1:0] ARADDR;
   logic [2:0]                ARPROT;
   logic                      RVALID;
   logic                      RREADY;
   logic [AXI_DATA_WIDTH-1:0] RDATA;
   logic [1:0]                RRESP;

   modport master (
      output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
             ARVALID, ARADDR, ARPROT, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite initiator: turns a core request/response
// handshake into one AXI4-lite read or write and returns data/status.
module axi_lite_master #(
   parameter int         AXI_ADDR_WIDTH = 32,
   parameter int         AXI_DATA_WIDTH = 32,
   parameter int         AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter logic [2:0] AXI_PROT       = 3'b000
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      ip_req,
   input  logic                      ip_wr1_rd0,
   input  logic [AXI_ADDR_WIDTH-1:0] ip_addr,
   input  logic [AXI_DATA_WIDTH-1:0] ip_write_data,
   input  logic [AXI_STRB_WIDTH-1:0] ip_byte_strobe,
   output logic                      ip_req_ready,
   output logic                      ip_rsp_valid,
   output logic [AXI_DATA_WIDTH-1:0] ip_read_data,
   output logic                      ip_rsp_err,
   axi_lite_master_if.master         m_axi
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA
   } state_t;

   state_t                    r_state,     w_state_next;
   logic                      r_awvalid,   w_awvalid_next;
   logic                      r_wvalid,    w_wvalid_next;
   logic                      r_bready,    w_bready_next;
   logic                      r_arvalid,   w_arvalid_next;
   logic                      r_rready,    w_rready_next;
   logic                      r_req_ready, w_req_ready_next;
   logic                      r_rsp_valid, w_rsp_valid_next;
   logic                      r_rsp_err,   w_rsp_err_next;
   logic [AXI_DATA_WIDTH-1:0] r_read_data, w_read_data_next;
   logic [AXI_ADDR_WIDTH-1:0] r_addr,      w_addr_next;
   logic [AXI_DATA_WIDTH-1:0] r_wdata,     w_wdata_next;
   logic [AXI_STRB_WIDTH-1:0] r_wstrb,     w_wstrb_next;

   // Only RESP[1] distinguishes error from success.
   logic w_unused_resp;
   assign w_unused_resp = &{1'b0, m_axi.BRESP[0], m_axi.RRESP[0]};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state     <= S_IDLE;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_read_data <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_awvalid   <= w_awvalid_next;
         r_wvalid    <= w_wvalid_next;
         r_bready    <= w_bready_next;
         r_arvalid   <= w_arvalid_next;
         r_rready    <= w_rready_next;
         r_req_ready <= w_req_ready_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_err   <= w_rsp_err_next;
         r_read_data <= w_read_data_next;
         r_addr      <= w_addr_next;
         r_wdata     <= w_wdata_next;
         r_wstrb     <= w_wstrb_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_awvalid_next   = r_awvalid;
      w_wvalid_next    = r_wvalid;
      w_bready_next    = r_bready;
      w_arvalid_next   = r_arvalid;
      w_rready_next    = r_rready;
      w_rsp_valid_next = 1'b0;
      w_rsp_err_next   = r_rsp_err;
      w_read_data_next = r_read_data;
      w_addr_next      = r_addr;
      w_wdata_next     = r_wdata;
      w_wstrb_next     = r_wstrb;

      case (r_state)
         S_IDLE: begin
            if (ip_req && r_req_ready) begin
               w_addr_next  = ip_addr;
               w_wdata_next = ip_write_data;
               w_wstrb_next = ip_byte_strobe;
               if (ip_wr1_rd0) begin
                  w_state_next   = S_WRITE;
                  w_awvalid_next = 1'b1;
                  w_wvalid_next  = 1'b1;
               end else begin
                  w_state_next   = S_READ;
                  w_arvalid_next = 1'b1;
               end
            end
         end
         S_WRITE: begin
            // AW and W retire independently; B is opened once both are gone.
            if (m_axi.AWREADY) w_awvalid_next = 1'b0;
            if (m_axi.WREADY)  w_wvalid_next  = 1'b0;
            if (!w_awvalid_next && !w_wvalid_next) begin
               w_state_next  = S_WRESP;
               w_bready_next = 1'b1;
            end
         end
         S_WRESP: begin
            if (m_axi.BVALID) begin
               w_bready_next    = 1'b0;
               w_rsp_err_next   = m_axi.BRESP[1];
               w_rsp_valid_next = 1'b1;
               w_state_next     = S_IDLE;
            end
         end
         S_READ: begin
            if (m_axi.ARREADY) begin
               w_arvalid_next = 1'b0;
               w_rready_next  = 1'b1;
               w_state_next   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (m_axi.RVALID) begin
               w_rready_next    = 1'b0;
               w_read_data_next = m_axi.RDATA;
               w_rsp_err_next   = m_axi.RRESP[1];
               w_rsp_valid_next = 1'b1;
               w_state_next     = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // Ready stays low through the response pulse so acceptance resumes one cycle later.
      w_req_ready_next = (w_state_next == S_IDLE) && !w_rsp_valid_next;
   end

   assign ip_req_ready  = r_req_ready;
   assign ip_rsp_valid  = r_rsp_valid;
   assign ip_rsp_err    = r_rsp_err;
   assign ip_read_data  = r_read_data;

   assign m_axi.AWVALID = r_awvalid;
   assign m_axi.AWADDR  = r_addr;
   assign m_axi.AWPROT  = AXI_PROT;
   assign m_axi.WVALID  = r_wvalid;
   assign m_axi.WDATA   = r_wdata;
   assign m_axi.WSTRB   = r_wstrb;
   assign m_axi.BREADY  = r_bready;
   assign m_axi.ARVALID = r_arvalid;
   assign m_axi.ARADDR  = r_addr;
   assign m_axi.ARPROT  = AXI_PROT;
   assign m_axi.RREADY  = r_rready;
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable target model, a table of
// directed transactions, then random traffic against a latency/result model.
module tb_axi_lite_master;
   localparam int BUDGET = 6000;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        ip_req;
   logic        ip_wr1_rd0;
   logic [31:0] ip_addr;
   logic [31:0] ip_write_data;
   logic [3:0]  ip_byte_strobe;
   logic        ip_req_ready;
   logic        ip_rsp_valid;
   logic [31:0] ip_read_data;
   logic        ip_rsp_err;

   axi_lite_master_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

   axi_lite_master #(
      .AXI_ADDR_WIDTH(32),
      .AXI_DATA_WIDTH(32),
      .AXI_PROT      (3'b000)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .ip_req        (ip_req),
      .ip_wr1_rd0    (ip_wr1_rd0),
      .ip_addr       (ip_addr),
      .ip_write_data (ip_write_data),
      .ip_byte_strobe(ip_byte_strobe),
      .ip_req_ready  (ip_req_ready),
      .ip_rsp_valid  (ip_rsp_valid),
      .ip_read_data  (ip_read_data),
      .ip_rsp_err    (ip_rsp_err),
      .m_axi         (bus)
   );

   initial forever #5 ACLK = ~ACLK;

   // Slave delays are counted in cycles of VALID (or of B/R being due) before READY/VALID.
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awd, wd, bd, ard, rd;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        early_b;
      logic        rst_wresp;
      int          gap;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } txn_t;

   txn_t q[$];
   txn_t tbl[10];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_valids"}, {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY}, 0);
      chk({tag, "_rsp"}, {ip_rsp_valid, ip_rsp_err}, 0);
      chk({tag, "_req_ready"}, ip_req_ready, 1);
      chk({tag, "_read_data"}, ip_read_data, 0);
      chk({tag, "_addr"}, {bus.AWADDR, bus.ARADDR}, 0);
      chk({tag, "_wdata"}, {bus.WSTRB, bus.WDATA}, 0);
   endtask

   function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awd, input int wd, input int bd,
                               input int ard, input int rd, input logic [1:0] resp,
                               input logic [31:0] rdata, input logic eb, input logic rs,
                               input int gap, input logic ee, input logic [31:0] er, input int el);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
      t.awd = awd; t.wd = wd; t.bd = bd; t.ard = ard; t.rd = rd;
      t.resp = resp; t.rdata = rdata; t.early_b = eb; t.rst_wresp = rs; t.gap = gap;
      t.exp_err = ee; t.exp_rdata = er; t.exp_lat = el;
      return t;
   endfunction

   task automatic run_queue();
      int   cyc = 0, pi = 0, ci = 0, gap_cnt = 0, t_acc = 0, n_done = 0, n_exp = 0;
      bit   busy = 0, post_rst = 0, ready_due = 0;
      bit   aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
      int   aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0;
      bit   p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
      bit   awhs, whs, arhs, bhs, rhs, both;
      txn_t cur;
      foreach (q[i]) if (!q[i].rst_wresp) n_exp++;
      cur = q[0];
      gap_cnt = q[0].gap;
      while ((pi < q.size() || busy) && cyc < BUDGET) begin
         @(negedge ACLK);
         cyc++;
         if (post_rst) begin
            ARESET = 1'b0;
            chk_rst("midrst");
            post_rst = 0;
         end
         if (busy) chk("req_ready_busy", ip_req_ready, 0);
         if (ready_due) begin
            chk("req_ready_after_rsp", ip_req_ready, 1);
            ready_due = 0;
         end
         if (ip_rsp_valid) begin
            if (!busy) chk("spurious_rsp", ip_rsp_valid, 0);
            else begin
               chk("rsp_err", ip_rsp_err, cur.exp_err);
               chk("rsp_read_data", ip_read_data, cur.exp_rdata);
               chk("rsp_latency", cyc - t_acc, cur.exp_lat);
               $display("txn %0d %s addr=0x%08h err=%0d rdata=0x%08h lat=%0d",
                        ci, cur.wr ? "WR" : "RD", cur.addr, ip_rsp_err, ip_read_data, cyc - t_acc);
               busy = 0; ready_due = 1; n_done++;
            end
         end
         if (p_awhs) chk("awvalid_drop", bus.AWVALID, 0);
         else if (p_awv) chk("awvalid_hold", bus.AWVALID, 1);
         if (p_whs) chk("wvalid_drop", bus.WVALID, 0);
         else if (p_wv) chk("wvalid_hold", bus.WVALID, 1);
         if (p_arhs) chk("arvalid_drop", bus.ARVALID, 0);
         else if (p_arv) chk("arvalid_hold", bus.ARVALID, 1);
         if (busy && cyc == t_acc + 1)
            chk("valid_after_accept", {bus.AWVALID, bus.WVALID, bus.ARVALID}, cur.wr ? 3'b110 : 3'b001);
         if (bus.AWVALID) begin
            if (busy && cur.wr) begin
               chk("awaddr", bus.AWADDR, cur.addr);
               chk("awprot", bus.AWPROT, 0);
            end else chk("awvalid_unexpected", bus.AWVALID, 0);
         end
         if (bus.WVALID) begin
            if (busy && cur.wr) chk("wdata_wstrb", {bus.WSTRB, bus.WDATA}, {cur.strb, cur.data});
            else chk("wvalid_unexpected", bus.WVALID, 0);
         end
         if (bus.ARVALID) begin
            if (busy && !cur.wr) chk("araddr_arprot", {bus.ARPROT, bus.ARADDR}, {3'b000, cur.addr});
            else chk("arvalid_unexpected", bus.ARVALID, 0);
         end
         if (bus.BREADY) chk("bready_early", busy && cur.wr && aw_done && w_done, 1);
         if (bus.RREADY) chk("rready_early", busy && !cur.wr && ar_done, 1);

         if (busy && cur.rst_wresp && bus.BREADY) begin
            ARESET = 1'b1;
            ip_req = 1'b0;
            bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RVALID = 0;
            busy = 0; post_rst = 1;
            p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
            $display("txn %0d WR addr=0x%08h abandoned by reset in WRESP", ci, cur.addr);
         end else begin
            both = aw_done && w_done;
            bus.AWREADY = busy && bus.AWVALID && aw_seen >= cur.awd;
            bus.WREADY  = busy && bus.WVALID && w_seen >= cur.wd;
            bus.BVALID  = busy && cur.wr && !b_done &&
                          ((cur.early_b && cyc >= t_acc + 3) || (both && b_cnt >= cur.bd));
            bus.BRESP   = bus.BVALID ? cur.resp : 2'b10;
            bus.ARREADY = busy && bus.ARVALID && ar_seen >= cur.ard;
            bus.RVALID  = busy && !cur.wr && ar_done && !r_done && r_cnt >= cur.rd;
            bus.RDATA   = bus.RVALID ? cur.rdata : $urandom;
            bus.RRESP   = bus.RVALID ? cur.resp : 2'b11;
            awhs = bus.AWVALID && bus.AWREADY;
            whs  = bus.WVALID && bus.WREADY;
            arhs = bus.ARVALID && bus.ARREADY;
            bhs  = bus.BVALID && bus.BREADY;
            rhs  = bus.RVALID && bus.RREADY;
            if (bus.AWVALID) aw_seen++;
            if (bus.WVALID)  w_seen++;
            if (bus.ARVALID) ar_seen++;
            if (both)        b_cnt++;
            if (ar_done)     r_cnt++;
            if (awhs) aw_done = 1;
            if (whs)  w_done = 1;
            if (arhs) ar_done = 1;
            if (bhs)  b_done = 1;
            if (rhs)  r_done = 1;
            p_awv = bus.AWVALID; p_awhs = awhs;
            p_wv = bus.WVALID;   p_whs = whs;
            p_arv = bus.ARVALID; p_arhs = arhs;

            if (pi < q.size()) begin
               if (gap_cnt > 0) begin
                  ip_req = 1'b0;
                  gap_cnt--;
               end else begin
                  ip_req = 1'b1;
                  ip_wr1_rd0 = q[pi].wr;
                  ip_addr = q[pi].addr;
                  ip_write_data = q[pi].data;
                  ip_byte_strobe = q[pi].strb;
                  if (ip_req_ready && !busy) begin
                     cur = q[pi]; ci = pi; busy = 1; t_acc = cyc;
                     aw_seen = 0; w_seen = 0; ar_seen = 0; b_cnt = 0; r_cnt = 0;
                     aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
                     pi++;
                     gap_cnt = (pi < q.size()) ? q[pi].gap : 0;
                  end
               end
            end else ip_req = 1'b0;
         end
      end
      chk("all_presented", pi, q.size());
      chk("rsp_count", n_done, n_exp);
      ip_req = 1'b0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RVALID = 0;
      repeat (2) @(negedge ACLK);
   endtask

   initial begin
      logic [31:0] prev_rdata;
      txn_t        t;
      ARESET = 1'b1;
      ip_req = 1'b0; ip_wr1_rd0 = 1'b0; ip_addr = '0; ip_write_data = '0; ip_byte_strobe = '0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
      bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      chk_rst("reset");

      //            wr    addr          data          strb  awd wd bd ard rd resp   rdata         eb rs gap err rdata_exp   lat
      tbl[0] = mk(1'b1, 32'h0000_0204, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 2, 0, 32'h0,         3);
      tbl[1] = mk(1'b1, 32'h0000_0208, 32'h1111_2222, 4'h3, 0, 4, 0, 0, 0, 2'b01, 32'h0,         1, 0, 0, 0, 32'h0,         7);
      tbl[2] = mk(1'b0, 32'h0000_0200, 32'h0,         4'h0, 0, 0, 0, 3, 2, 2'b00, 32'h0000_0007, 0, 0, 1, 0, 32'h0000_0007, 8);
      tbl[3] = mk(1'b0, 32'h0000_0300, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b11, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'hDEAD_BEEF, 3);
      tbl[4] = mk(1'b1, 32'h0000_0304, 32'h0BAD_F00D, 4'h9, 1, 0, 2, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 6);
      tbl[5] = mk(1'b1, 32'h0000_0400, 32'h7777_8888, 4'hF, 0, 0, 3, 0, 0, 2'b00, 32'h0,         0, 1, 1, 0, 32'h0,         0);
      tbl[6] = mk(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hC, 0, 0, 0, 0, 0, 2'b10, 32'h0,         0, 0, 0, 1, 32'h0,         3);
      tbl[7] = mk(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 32'h0,         3);
      tbl[8] = mk(1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b01, 32'h0000_0055, 0, 0, 0, 0, 32'h0000_0055, 3);
      tbl[9] = mk(1'b1, 32'h0000_0028, 32'hCAFE_0003, 4'h1, 0, 0, 0, 0, 0, 2'b11, 32'h0,         0, 0, 0, 1, 32'h0000_0055, 3);
      q.delete();
      foreach (tbl[i]) q.push_back(tbl[i]);
      run_queue();

      // Random traffic: results follow from the RESP/RDATA the target returns and the
      // latency from the handshake delays (zero-wait = 3 cycles, each wait adds one).
      prev_rdata = 32'h0000_0055;
      q.delete();
      for (int i = 0; i < 40; i++) begin
         t.wr = 1'($urandom_range(0, 1));
         t.addr = $urandom & 32'hFFFF_FFFC;
         t.data = $urandom;
         t.strb = 4'($urandom_range(0, 15));
         t.awd = $urandom_range(0, 3); t.wd = $urandom_range(0, 3); t.bd = $urandom_range(0, 3);
         t.ard = $urandom_range(0, 3); t.rd = $urandom_range(0, 3);
         t.resp = 2'($urandom_range(0, 3));
         t.rdata = $urandom;
         t.early_b = 1'b0; t.rst_wresp = 1'b0;
         t.gap = $urandom_range(0, 5);
         t.exp_err = (t.resp >= 2'b10);
         if (!t.wr) prev_rdata = t.rdata;
         t.exp_rdata = prev_rdata;
         t.exp_lat = t.wr ? 3 + ((t.awd > t.wd) ? t.awd : t.wd) + t.bd : 3 + t.ard + t.rd;
         q.push_back(t);
      end
      run_queue();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
